viterbi_ctrl: RTL and testbench

Frame sequencer for the hard-decision Viterbi decoder (K=3, 4 states, register-exchange survivor memory of DEPTH stages). It accepts a stream of 2-bit received symbols over a valid/ready handshake and advances the BMU/ACS/survivor datapath one trellis step per accepted symbol. It clears the datapath at frame start, appends zero-symbol flush steps at frame end, triggers path-metric normalisation, and frames the decoded bit stream with valid/last.

---
 rtl/viterbi_pkg.sv | 28 ++
 rtl/vit_pm_min.sv | 26 ++
 rtl/viterbi_ctrl.sv | 156 +++++++++++++++
 tb/tb_viterbi_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the hard-decision K=3 Viterbi decoder slice.
// Holds the controller state encoding, the received-symbol type and the metric reset values.
package viterbi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH
  } vit_state_e;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_ZERO    = 2'b00;
  localparam int   DEPTH_DEF   = 15;
  localparam int   PM_W_DEF    = 4;
  localparam int   NORM_TH_DEF = 8;
  localparam int   CNT_W_DEF   = 16;

  // The trellis always starts in state 0, so every other state is made maximally unlikely.
  localparam logic [PM_W_DEF-1:0] PM_CLR_S0    = '0;
  localparam logic [PM_W_DEF-1:0] PM_CLR_OTHER = '1;

  function automatic logic [PM_W_DEF-1:0] pm_clr_val(input logic [1:0] stateIdx);
    return (stateIdx == 2'd0) ? PM_CLR_S0 : PM_CLR_OTHER;
  endfunction

endpackage

// File: rtl/vit_pm_min.sv
// Combinational minimum of the four path metrics and the normalisation-needed flag.
module vit_pm_min
  import viterbi_pkg::*;
#(
  parameter int PM_W    = PM_W_DEF,
  parameter int NORM_TH = NORM_TH_DEF
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [PM_W-1:0] pm2_i,
  input  logic [PM_W-1:0] pm3_i,
  output logic            norm_o
);

  localparam logic [PM_W-1:0] TH = PM_W'(NORM_TH);

  logic [PM_W-1:0] min01;
  logic [PM_W-1:0] min23;
  logic [PM_W-1:0] minAll;

  assign min01  = (pm1_i < pm0_i) ? pm1_i : pm0_i;
  assign min23  = (pm3_i < pm2_i) ? pm3_i : pm2_i;
  assign minAll = (min23 < min01) ? min23 : min01;
  assign norm_o = (minAll >= TH);

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the Viterbi datapath: clears it, steps it once per accepted symbol,
// appends zero-symbol flush steps and frames the decoded bit stream with valid/last.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PM_W    = PM_W_DEF,
  parameter int NORM_TH = NORM_TH_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sym_valid,
  output logic            sym_ready,
  input  logic [1:0]      sym_in,
  input  logic            sym_last,
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [PM_W-1:0] pm2,
  input  logic [PM_W-1:0] pm3,
  input  logic            spd_bit,
  output logic            acs_en,
  output logic [1:0]      acs_sym,
  output logic            pm_norm,
  output logic            dp_clr,
  output logic            dec_valid,
  output logic            dec_bit,
  output logic            dec_last,
  output logic            busy
);

  localparam int STEP_W  = CNT_W + 1;
  localparam int FLUSH_W = $clog2(DEPTH) + 1;

  localparam logic [STEP_W-1:0]  LAT         = STEP_W'(DEPTH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_STEPS = FLUSH_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   IN_SAT      = '1;

  vit_state_e          state_q;
  logic [CNT_W-1:0]    in_cnt_q;
  logic [STEP_W-1:0]   step_cnt_q;
  logic [FLUSH_W-1:0]  flush_cnt_q;
  logic                sym_ready_q;
  logic                acs_en_q;
  sym_t                acs_sym_q;
  logic                pm_norm_q;
  logic                dp_clr_q;
  logic                dec_valid_q;
  logic                dec_last_q;

  logic                handshake;
  logic                frameEnd;
  logic                normHit;
  logic [STEP_W-1:0]   inCntExt;
  logic [STEP_W-1:0]   decIdx;
  logic                dec_valid_d;
  logic                dec_last_d;

  vit_pm_min #(
    .PM_W    (PM_W),
    .NORM_TH (NORM_TH)
  ) u_pm_min (
    .pm0_i  (pm0),
    .pm1_i  (pm1),
    .pm2_i  (pm2),
    .pm3_i  (pm3),
    .norm_o (normHit)
  );

  assign handshake = sym_valid & sym_ready_q;

  // A counter about to saturate ends the frame exactly as an explicit sym_last would.
  assign frameEnd = sym_last | (in_cnt_q == IN_SAT - 1'b1);

  // step_cnt_q is the index of the step currently on acs_en; the survivor output belongs to
  // input bit (step - (DEPTH-1)) once the memory is full, and only real input bits are emitted.
  assign inCntExt    = {1'b0, in_cnt_q};
  assign decIdx      = step_cnt_q - LAT;
  assign dec_valid_d = acs_en_q && (step_cnt_q >= LAT) && (decIdx < inCntExt);
  assign dec_last_d  = dec_valid_d && (decIdx == inCntExt - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      step_cnt_q  <= '0;
      flush_cnt_q <= '0;
      sym_ready_q <= 1'b0;
      acs_en_q    <= 1'b0;
      acs_sym_q   <= SYM_ZERO;
      pm_norm_q   <= 1'b0;
      dp_clr_q    <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_last_q  <= 1'b0;
    end else begin
      acs_en_q    <= 1'b0;
      pm_norm_q   <= 1'b0;
      dp_clr_q    <= 1'b0;
      dec_valid_q <= dec_valid_d;
      dec_last_q  <= dec_last_d;
      if (acs_en_q) begin
        step_cnt_q <= step_cnt_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (sym_valid) begin
            state_q  <= ST_CLEAR;
            dp_clr_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          in_cnt_q    <= '0;
          step_cnt_q  <= '0;
          flush_cnt_q <= '0;
          sym_ready_q <= 1'b1;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (handshake) begin
            acs_en_q  <= 1'b1;
            acs_sym_q <= sym_in;
            pm_norm_q <= normHit;
            in_cnt_q  <= in_cnt_q + 1'b1;
            if (frameEnd) begin
              sym_ready_q <= 1'b0;
              state_q     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Stay one extra cycle after the last flush step so busy drops with the final bit.
          if (flush_cnt_q == FLUSH_STEPS) begin
            state_q <= ST_IDLE;
          end else begin
            acs_en_q    <= 1'b1;
            acs_sym_q   <= SYM_ZERO;
            pm_norm_q   <= normHit;
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sym_ready = sym_ready_q;
  assign acs_en    = acs_en_q;
  assign acs_sym   = acs_sym_q;
  assign pm_norm   = pm_norm_q;
  assign dp_clr    = dp_clr_q;
  assign dec_valid = dec_valid_q;
  assign dec_bit   = dec_valid_q & spd_bit;
  assign dec_last  = dec_last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed bench for viterbi_ctrl with a delay-line stand-in for the survivor memory,
// so the decoded bit for input j is bit 1 of the j-th accepted symbol.
module tb_viterbi_ctrl;

  localparam int DEPTH = 15;
  localparam int PM_W  = 4;

  logic clk = 1'b0;
  logic reset;
  logic sym_valid;
  logic sym_ready;
  logic [1:0] sym_in;
  logic sym_last;
  logic [PM_W-1:0] pm0, pm1, pm2, pm3;
  logic spd_bit;
  logic acs_en;
  logic [1:0] acs_sym;
  logic pm_norm;
  logic dp_clr;
  logic dec_valid;
  logic dec_bit;
  logic dec_last;
  logic busy;

  always #5 clk = ~clk;

  viterbi_ctrl #(
    .DEPTH   (DEPTH),
    .PM_W    (PM_W),
    .NORM_TH (8),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_in    (sym_in),
    .sym_last  (sym_last),
    .pm0       (pm0),
    .pm1       (pm1),
    .pm2       (pm2),
    .pm3       (pm3),
    .spd_bit   (spd_bit),
    .acs_en    (acs_en),
    .acs_sym   (acs_sym),
    .pm_norm   (pm_norm),
    .dp_clr    (dp_clr),
    .dec_valid (dec_valid),
    .dec_bit   (dec_bit),
    .dec_last  (dec_last),
    .busy      (busy)
  );

  logic [1:0] hist [DEPTH];

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= 2'b00;
    end else if (acs_en) begin
      hist[0] <= acs_sym;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  assign spd_bit = hist[DEPTH-1][1];

  int assertCount = 0;
  int failCount   = 0;

  logic [1:0] symTab [20];
  logic [3:0] pmTab [16][4];

  int cycleCount = 0;
  int acsEnCount, dpClrCount, decLastCount, hsCount, strayCount;
  int firstAcs, lastAcs, firstDec, readyCycle;
  logic prevBusy;
  logic [1:0] acsSymQ [$];
  logic normQ [$];
  logic decBits [$];
  int lastIdxQ [$];
  logic busyAtLastQ [$];
  logic prevBusyAtLastQ [$];
  int dpClrCycles [$];
  int busyFallCycles [$];

  logic [1:0] expAcsQ [$];
  logic expBits [$];
  int expLastIdx [$];

  always @(negedge clk) begin
    cycleCount++;
    if (dp_clr === 1'b1) begin
      dpClrCount++;
      dpClrCycles.push_back(cycleCount);
    end
    if (sym_ready === 1'b1 && readyCycle < 0) readyCycle = cycleCount;
    if (acs_en === 1'b1) begin
      acsEnCount++;
      acsSymQ.push_back(acs_sym);
      normQ.push_back(pm_norm);
      if (firstAcs < 0) firstAcs = cycleCount;
      lastAcs = cycleCount;
    end
    if (pm_norm === 1'b1 && acs_en !== 1'b1) strayCount++;
    if (dec_valid === 1'b1) begin
      decBits.push_back(dec_bit);
      if (firstDec < 0) firstDec = cycleCount;
    end
    if (dec_last === 1'b1) begin
      decLastCount++;
      lastIdxQ.push_back(decBits.size() - 1);
      busyAtLastQ.push_back(busy);
      prevBusyAtLastQ.push_back(prevBusy);
      if (dec_valid !== 1'b1) strayCount++;
    end
    if (prevBusy === 1'b1 && busy === 1'b0) busyFallCycles.push_back(cycleCount);
    prevBusy = busy;
  end

  always @(posedge clk) begin
    if (sym_valid === 1'b1 && sym_ready === 1'b1 && reset === 1'b0) hsCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic resetCounters();
    acsEnCount = 0; dpClrCount = 0; decLastCount = 0; hsCount = 0; strayCount = 0;
    firstAcs = -1; lastAcs = -1; firstDec = -1; readyCycle = -1;
    acsSymQ.delete(); normQ.delete(); decBits.delete(); lastIdxQ.delete();
    busyAtLastQ.delete(); prevBusyAtLastQ.delete(); dpClrCycles.delete(); busyFallCycles.delete();
    expAcsQ.delete(); expBits.delete(); expLastIdx.delete();
  endtask

  task automatic applyStimulus(input int n, input int offset, input bit toggle, input bit holdValid, input int abortAt);
    logic [1:0] s;
    bit gap;
    bit taken;
    logic frameBits [$];
    gap = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = symTab[(offset + i) % 20];
      if (i == abortAt) begin
        @(negedge clk);
        reset = 1'b1; sym_valid = 1'b0; sym_last = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      taken = 1'b0;
      for (int w = 0; w < 200 && !taken; w++) begin
        @(negedge clk);
        if (gap) begin
          sym_valid = 1'b0;
          gap = 1'b0;
        end else begin
          sym_valid = 1'b1; sym_in = s; sym_last = (i == n - 1);
          pm0 = pmTab[i % 16][0]; pm1 = pmTab[i % 16][1];
          pm2 = pmTab[i % 16][2]; pm3 = pmTab[i % 16][3];
          if (sym_ready === 1'b1) begin
            taken = 1'b1;
            gap = toggle;
          end
        end
      end
      if (!taken) begin
        checkOutput("hsTimeout", {31'd0, taken}, 32'd1);
        return;
      end
      expAcsQ.push_back(s);
      frameBits.push_back(s[1]);
    end
    for (int k = 0; k < DEPTH - 1; k++) expAcsQ.push_back(2'b00);
    foreach (frameBits[k]) expBits.push_back(frameBits[k]);
    expLastIdx.push_back(expBits.size() - 1);
    @(negedge clk);
    sym_last = 1'b0;
    if (!holdValid) sym_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int w = 0; w < 100 && busy === 1'b1; w++) @(negedge clk);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkFrame(input string tag, input int nFrames);
    int errs;
    checkOutput({tag, "_acsCount"}, acsEnCount, expAcsQ.size());
    errs = 0;
    for (int k = 0; k < acsSymQ.size(); k++)
      if (k >= expAcsQ.size() || acsSymQ[k] !== expAcsQ[k]) errs++;
    checkOutput({tag, "_acsSeq"}, errs, 0);
    checkOutput({tag, "_decCount"}, decBits.size(), expBits.size());
    errs = 0;
    for (int k = 0; k < decBits.size(); k++)
      if (k >= expBits.size() || decBits[k] !== expBits[k]) errs++;
    checkOutput({tag, "_decBits"}, errs, 0);
    checkOutput({tag, "_lastCount"}, decLastCount, nFrames);
    checkOutput({tag, "_clrCount"}, dpClrCount, nFrames);
    errs = (lastIdxQ.size() == expLastIdx.size()) ? 0 : 1;
    for (int k = 0; k < lastIdxQ.size(); k++)
      if (k >= expLastIdx.size() || lastIdxQ[k] != expLastIdx[k]) errs++;
    checkOutput({tag, "_lastPos"}, errs, 0);
    errs = 0;
    for (int k = 0; k < busyAtLastQ.size(); k++)
      if (busyAtLastQ[k] !== 1'b0 || prevBusyAtLastQ[k] !== 1'b1) errs++;
    checkOutput({tag, "_busyFall"}, errs, 0);
    checkOutput({tag, "_stray"}, strayCount, 0);
  endtask

  initial begin
    logic [3:0] normObs;
    int gapVal;
    int normOnes;

    symTab = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00,
               2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++) pmTab[i][k] = 4'd0;

    reset = 1'b1; sym_valid = 1'b0; sym_in = 2'b00; sym_last = 1'b0;
    pm0 = 4'd0; pm1 = 4'd0; pm2 = 4'd0; pm3 = 4'd0;
    prevBusy = 1'b0;
    resetCounters();

    repeat (3) @(negedge clk);
    checkOutput("rst_symReady", {31'd0, sym_ready}, 32'd0);
    checkOutput("rst_acsEn",    {31'd0, acs_en},    32'd0);
    checkOutput("rst_acsSym",   {30'd0, acs_sym},   32'd0);
    checkOutput("rst_pmNorm",   {31'd0, pm_norm},   32'd0);
    checkOutput("rst_dpClr",    {31'd0, dp_clr},    32'd0);
    checkOutput("rst_decValid", {31'd0, dec_valid}, 32'd0);
    checkOutput("rst_decBit",   {31'd0, dec_bit},   32'd0);
    checkOutput("rst_decLast",  {31'd0, dec_last},  32'd0);
    checkOutput("rst_busy",     {31'd0, busy},      32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] 20-symbol continuous frame");
    resetCounters();
    applyStimulus(20, 0, 1'b0, 1'b0, -1);
    waitIdle("t2");
    checkFrame("t2", 1);
    gapVal = (dpClrCycles.size() > 0) ? readyCycle - dpClrCycles[0] : -1;
    checkOutput("t2_clrToReady", gapVal, 1);
    checkOutput("t2_decLatency", firstDec - firstAcs, DEPTH);
    checkOutput("t2_stepsBackToBack", lastAcs - firstAcs, 20 + DEPTH - 2);

    $display("[TB] 1-symbol frame");
    resetCounters();
    applyStimulus(1, 5, 1'b0, 1'b0, -1);
    waitIdle("t3");
    checkFrame("t3", 1);
    checkOutput("t3_steps", acsEnCount, 1 + DEPTH - 1);

    $display("[TB] toggled sym_valid frame");
    resetCounters();
    applyStimulus(8, 2, 1'b1, 1'b0, -1);
    waitIdle("t4");
    checkFrame("t4", 1);
    checkOutput("t4_handshakes", hsCount, 8);

    $display("[TB] normalisation thresholds");
    pmTab[0] = '{4'd9,  4'd10, 4'd12, 4'd15};
    pmTab[1] = '{4'd7,  4'd9,  4'd9,  4'd9};
    pmTab[2] = '{4'd12, 4'd8,  4'd15, 4'd9};
    pmTab[3] = '{4'd15, 4'd15, 4'd15, 4'd7};
    resetCounters();
    applyStimulus(4, 9, 1'b0, 1'b0, -1);
    waitIdle("t5");
    checkFrame("t5", 1);
    normObs = 4'd0;
    normOnes = 0;
    for (int k = 0; k < normQ.size(); k++) begin
      if (k < 4) normObs[k] = normQ[k];
      if (normQ[k] === 1'b1) normOnes++;
    end
    checkOutput("t5_normSteps", {28'd0, normObs}, 32'b0101);
    checkOutput("t5_normCount", normOnes, 2);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) pmTab[i][k] = 4'd0;
    pm0 = 4'd0; pm1 = 4'd0; pm2 = 4'd0; pm3 = 4'd0;

    $display("[TB] reset mid-frame then fresh frame");
    resetCounters();
    applyStimulus(10, 0, 1'b0, 1'b0, 4);
    repeat (20) @(negedge clk);
    checkOutput("t6_abortDec",   decBits.size(), 0);
    checkOutput("t6_abortLast",  decLastCount, 0);
    checkOutput("t6_abortBusy",  {31'd0, busy}, 32'd0);
    checkOutput("t6_abortSteps", acsEnCount, 4);
    resetCounters();
    applyStimulus(3, 12, 1'b0, 1'b0, -1);
    waitIdle("t6");
    checkFrame("t6", 1);

    $display("[TB] back-to-back frames of 4 and 6");
    resetCounters();
    applyStimulus(4, 3, 1'b0, 1'b1, -1);
    applyStimulus(6, 7, 1'b0, 1'b0, -1);
    waitIdle("t7");
    checkFrame("t7", 2);
    gapVal = (dpClrCycles.size() > 1 && busyFallCycles.size() > 0) ? dpClrCycles[1] - busyFallCycles[0] : -1;
    checkOutput("t7_clearGap", gapVal, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
